// File: rtl/oscillo_pkg.sv
// Shared types and constants for the acquisition readout path.
package oscillo_pkg;

    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 3;
    localparam int unsigned LAT_CNT_W  = 2;
    localparam logic [7:0]  HDR_SYNC   = 8'hAA;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_SEND  = 3'd4,
        ST_DONE  = 3'd5
    } rd_state_e;

    // RAM read latency must fit the wait counter and the supported RAM configurations
    function automatic bit rd_lat_ok(input int unsigned lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/readout_addr_gen.sv
// Address generator for the readout: latches the readout window, walks samples and channels.
// READOUT_HEADER_EN: exposes latched start/mask for the header and reports emptiness from latched values.
module readout_addr_gen
    import oscillo_pkg::*;
#(
    parameter int unsigned RAM_WIDTH = 10,
    parameter int unsigned NCHAN     = 4,
    localparam int unsigned CH_W     = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 advance,
    input  logic [RAM_WIDTH-1:0] wtp,
    input  logic [RAM_WIDTH-1:0] tp,
    input  logic [RAM_WIDTH-1:0] nsmp,
    input  logic [NCHAN-1:0]     chanmask,
`ifdef READOUT_HEADER_EN
    output logic [RAM_WIDTH-1:0] start_q,
    output logic [NCHAN-1:0]     mask_q,
`endif
    output logic [CH_W-1:0]      ch_q,
    output logic [RAM_WIDTH-1:0] addr_nxt_c,
    output logic                 empty_c,
    output logic                 last_c
);

`ifndef READOUT_HEADER_EN
    logic [RAM_WIDTH-1:0] start_q;
    logic [NCHAN-1:0]     mask_q;
`endif
    logic [RAM_WIDTH-1:0] start_d, nsmp_q, nsmp_d, k_q, k_d;
    logic [NCHAN-1:0]     mask_d;
    logic [CH_W-1:0]      ch_d, first_ch, nxt_ch;
    logic                 nxt_found, last_k;

    // Priority encoders: lowest channel of the incoming mask, next latched channel above ch_q
    always_comb begin
        first_ch  = '0;
        nxt_ch    = '0;
        nxt_found = 1'b0;
        for (int unsigned c = NCHAN; c > 0; c--) begin
            if (chanmask[c-1]) begin
                first_ch = CH_W'(c - 1);
            end
            if (mask_q[c-1] && ((c - 1) > 32'(ch_q))) begin
                nxt_ch    = CH_W'(c - 1);
                nxt_found = 1'b1;
            end
        end
    end

    // Sample/channel stepping and next read address (modulo RAM depth)
    always_comb begin
        start_d = start_q;
        mask_d  = mask_q;
        nsmp_d  = nsmp_q;
        ch_d    = ch_q;
        k_d     = k_q;
        last_k  = (k_q == (nsmp_q - RAM_WIDTH'(1)));
        if (load) begin
            start_d = wtp - tp;
            mask_d  = chanmask;
            nsmp_d  = nsmp;
            ch_d    = first_ch;
            k_d     = '0;
        end else if (advance) begin
            if (last_k) begin
                k_d = '0;
                if (nxt_found) begin
                    ch_d = nxt_ch;
                end
            end else begin
                k_d = k_q + RAM_WIDTH'(1);
            end
        end
        addr_nxt_c = start_d + k_d;
        last_c     = last_k && !nxt_found;
`ifdef READOUT_HEADER_EN
        empty_c    = (mask_q == '0) || (nsmp_q == '0);
`else
        empty_c    = (chanmask == '0) || (nsmp == '0);
`endif
    end

    // Latched readout window and position
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q <= '0;
            mask_q  <= '0;
            nsmp_q  <= '0;
            ch_q    <= '0;
            k_q     <= '0;
        end else begin
            start_q <= start_d;
            mask_q  <= mask_d;
            nsmp_q  <= nsmp_d;
            ch_q    <= ch_d;
            k_q     <= k_d;
        end
    end

endmodule

// File: rtl/sample_readout.sv
// Streams acquisition RAM contents to the host transmitter, one byte per sample per enabled channel.
// READOUT_HEADER_EN: prepend a 4-byte header (sync, mask, start high, start low).
module sample_readout
    import oscillo_pkg::*;
#(
    parameter int unsigned RAM_WIDTH = 10,
    parameter int unsigned NCHAN     = 4,
    parameter int unsigned RD_LAT    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 data_ready,
    input  logic                 start_read,
    input  logic [RAM_WIDTH-1:0] wraddress_triggerpoint,
    input  logic [RAM_WIDTH-1:0] triggerpoint,
    input  logic [RAM_WIDTH-1:0] nsmp,
    input  logic [NCHAN-1:0]     chanmask,
    output logic                 rden,
    output logic [RAM_WIDTH-1:0] rdaddress,
    input  logic [8*NCHAN-1:0]   ram_q,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic                 readout_done,
    output logic                 readout_abort
);

    localparam int unsigned CH_W = (NCHAN > 1) ? $clog2(NCHAN) : 1;

    if (!rd_lat_ok(RD_LAT)) begin : g_rd_lat_chk
        $error("sample_readout: RD_LAT outside supported range");
    end

    rd_state_e              state_q, state_d;
    logic [LAT_CNT_W-1:0]   wcnt_q, wcnt_d;
    logic [7:0]             tx_data_q, tx_data_d, ch_byte;
    logic                   tx_valid_q, tx_valid_d;
    logic                   rden_q, rden_d;
    logic [RAM_WIDTH-1:0]   rdaddress_q, rdaddress_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   abort_q, abort_d;
    logic                   load, advance, active, finishing;
    logic [CH_W-1:0]        ch_q;
    logic [RAM_WIDTH-1:0]   addr_nxt_c;
    logic                   empty_c, last_c;
`ifdef READOUT_HEADER_EN
    logic [2:0]             hdr_idx_q, hdr_idx_d;
    logic [7:0]             hdr_byte;
    logic [RAM_WIDTH-1:0]   start_q;
    logic [NCHAN-1:0]       mask_q;
`endif

    readout_addr_gen #(
        .RAM_WIDTH (RAM_WIDTH),
        .NCHAN     (NCHAN)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .advance    (advance),
        .wtp        (wraddress_triggerpoint),
        .tp         (triggerpoint),
        .nsmp       (nsmp),
        .chanmask   (chanmask),
`ifdef READOUT_HEADER_EN
        .start_q    (start_q),
        .mask_q     (mask_q),
`endif
        .ch_q       (ch_q),
        .addr_nxt_c (addr_nxt_c),
        .empty_c    (empty_c),
        .last_c     (last_c)
    );

    // Select the current channel's byte from the RAM output bus
    always_comb begin
        ch_byte = 8'h00;
        for (int unsigned c = 0; c < NCHAN; c++) begin
            if (ch_q == CH_W'(c)) begin
                ch_byte = ram_q[8*c +: 8];
            end
        end
    end

`ifdef READOUT_HEADER_EN
    // Header byte for the current header index
    always_comb begin
        case (hdr_idx_q)
            3'd0:    hdr_byte = HDR_SYNC;
            3'd1:    hdr_byte = 8'(mask_q);
            3'd2:    hdr_byte = 8'(start_q >> 8);
            default: hdr_byte = 8'(start_q);
        endcase
    end
`endif

    // Next-state, tx register and status pulses
    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        load       = 1'b0;
        advance    = 1'b0;
`ifdef READOUT_HEADER_EN
        hdr_idx_d  = hdr_idx_q;
`endif
        active     = (state_q == ST_HDR) || (state_q == ST_ISSUE) ||
                     (state_q == ST_WAIT) || (state_q == ST_SEND);
        finishing  = (state_q == ST_SEND) && tx_ready && last_c;
        case (state_q)
            ST_IDLE: begin
                if (start_read && data_ready && !busy_q) begin
                    load = 1'b1;
`ifdef READOUT_HEADER_EN
                    state_d   = ST_HDR;
                    hdr_idx_d = '0;
`else
                    state_d   = empty_c ? ST_DONE : ST_ISSUE;
`endif
                end
            end
`ifdef READOUT_HEADER_EN
            ST_HDR: begin
                if (tx_valid_q) begin
                    if (tx_ready) begin
                        tx_valid_d = 1'b0;
                        hdr_idx_d  = hdr_idx_q + 3'd1;
                    end
                end else if (hdr_idx_q < 3'd4) begin
                    tx_data_d  = hdr_byte;
                    tx_valid_d = 1'b1;
                end else begin
                    state_d = empty_c ? ST_DONE : ST_ISSUE;
                end
            end
`endif
            ST_ISSUE: begin
                wcnt_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (wcnt_q == LAT_CNT_W'(RD_LAT - 1)) begin
                    tx_data_d  = ch_byte;
                    tx_valid_d = 1'b1;
                    state_d    = ST_SEND;
                end else begin
                    wcnt_d = wcnt_q + LAT_CNT_W'(1);
                end
            end
            ST_SEND: begin
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    advance    = 1'b1;
                    state_d    = last_c ? ST_DONE : ST_ISSUE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Losing data_ready aborts, unless this cycle completes the final byte
        abort_d = active && !data_ready && !finishing;
        if (abort_d) begin
            state_d    = ST_IDLE;
            tx_valid_d = 1'b0;
        end
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // RAM read request for the sample about to be fetched
    always_comb begin
        rden_d      = (state_d == ST_ISSUE);
        rdaddress_d = rden_d ? addr_nxt_c : rdaddress_q;
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            rden_q      <= 1'b0;
            rdaddress_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
`ifdef READOUT_HEADER_EN
            hdr_idx_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            rden_q      <= rden_d;
            rdaddress_q <= rdaddress_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
`ifdef READOUT_HEADER_EN
            hdr_idx_q   <= hdr_idx_d;
`endif
        end
    end

    assign rden          = rden_q;
    assign rdaddress     = rdaddress_q;
    assign tx_data       = tx_data_q;
    assign tx_valid      = tx_valid_q;
    assign busy          = busy_q;
    assign readout_done  = done_q;
    assign readout_abort = abort_q;

endmodule
